// File: rtl/mem_load_responder.sv
// Load responder: turns tagged byte-address loads into SRAM reads and returns
// {tag, data} in acceptance order through a response FIFO with backpressure.
module mem_load_responder #(
  parameter int ADDR_WIDTH  = 48,
  parameter int TAG_WIDTH   = 2,
  parameter int SRAM_AWIDTH = 17,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_mem_ld,
  input  logic [ADDR_WIDTH-1:0]  req_mem_addr,
  input  logic [TAG_WIDTH-1:0]   req_mem_tag,
  output logic                   req_mem_stall,
  output logic                   rsp_mem_push,
  output logic [TAG_WIDTH-1:0]   rsp_mem_tag,
  output logic [63:0]            rsp_mem_q,
  input  logic                   rsp_mem_stall,
  output logic                   sram_rd,
  output logic [SRAM_AWIDTH-1:0] sram_addr,
  input  logic [63:0]            sram_q,
  output logic                   err,
  output logic [31:0]            rsp_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = TAG_WIDTH + 64;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;
  logic [EW-1:0]    fifo_mem [FIFO_DEPTH];

  logic                 inflight_v;
  logic [TAG_WIDTH-1:0] inflight_tag;
  logic                 inflight_err;

  logic        accept;
  logic        addr_err;
  logic        fifo_wr;
  logic        fifo_pop;
  logic [63:0] wr_data;

  // Handshakes: a request transfers on a rising edge with req_mem_ld=1 and
  // req_mem_stall=0; a response transfers on the edge rsp_mem_push is seen high
  // (rsp_mem_stall=0 at an edge lets the next FIFO entry be presented).
  // Stall counts the in-flight slot so a full FIFO can always absorb it.
  assign occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_v};
  assign req_mem_stall = ~rst_n | (occupancy >= (CW+1)'(FIFO_DEPTH));
  assign accept        = req_mem_ld & ~req_mem_stall;

  assign sram_rd   = accept;
  assign sram_addr = req_mem_addr[SRAM_AWIDTH+2:3];

  assign addr_err = (req_mem_addr[2:0] != 3'b000) |
                    ((req_mem_addr >> (SRAM_AWIDTH + 3)) != '0);

  assign fifo_wr  = inflight_v;
  assign fifo_pop = (fifo_count != '0) & ~rsp_mem_stall;
  assign wr_data  = inflight_err ? 64'd0 : sram_q;

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= {inflight_tag, wr_data};
    end
  end

  // Pop decision uses the pre-write count, so a write into an empty FIFO
  // only becomes visible at the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_v   <= 1'b0;
      inflight_tag <= '0;
      inflight_err <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      rsp_mem_push <= 1'b0;
      rsp_mem_tag  <= '0;
      rsp_mem_q    <= '0;
      err          <= 1'b0;
      rsp_count    <= '0;
    end else begin
      inflight_v <= accept;
      if (accept) begin
        inflight_tag <= req_mem_tag;
        inflight_err <= addr_err;
      end
      if (accept && addr_err) begin
        err <= 1'b1;
      end
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr       <= rd_ptr + PW'(1);
        rsp_mem_push <= 1'b1;
        rsp_mem_tag  <= fifo_mem[rd_ptr][EW-1:64];
        rsp_mem_q    <= fifo_mem[rd_ptr][63:0];
        rsp_count    <= rsp_count + 32'd1;
      end else begin
        rsp_mem_push <= 1'b0;
      end
      fifo_count <= fifo_count + CW'(fifo_wr) - CW'(fifo_pop);
    end
  end

endmodule

// File: doc/mem_load_responder.md
MEM_LOAD_RESPONDER -- requirements
Module: mem_load_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 48, byte-address width of req_mem_addr.
REQ-002 SHALL have parameter TAG_WIDTH, default 2, width of request and response tags.
REQ-003 SHALL have parameter SRAM_AWIDTH, default 17, 64-bit-word address width of the backing SRAM.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8 (power of two, >=2), response FIFO entries.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port req_mem_ld, input, 1, load request valid.
REQ-008 SHALL have port req_mem_addr, input, ADDR_WIDTH, byte address.
REQ-009 SHALL have port req_mem_tag, input, TAG_WIDTH, request tag.
REQ-010 SHALL have port req_mem_stall, output, 1, request backpressure.
REQ-011 SHALL have port rsp_mem_push, output, 1, response valid.
REQ-012 SHALL have port rsp_mem_tag, output, TAG_WIDTH, tag of the response.
REQ-013 SHALL have port rsp_mem_q, output, 64, response data.
REQ-014 SHALL have port rsp_mem_stall, input, 1, response backpressure.
REQ-015 SHALL have port sram_rd, output, 1, SRAM read enable.
REQ-016 SHALL have port sram_addr, output, SRAM_AWIDTH, SRAM word address.
REQ-017 SHALL have port sram_q, input, 64, SRAM read data, valid the cycle after sram_rd.
REQ-018 SHALL have port err, output, 1, sticky address-error flag.
REQ-019 SHALL have port rsp_count, output, 32, responses pushed since reset.

Function
REQ-020 SHALL accept a request at a rising edge where req_mem_ld=1 and req_mem_stall=0; req_mem_ld while stalled SHALL be ignored, with no response.
REQ-021 SHALL drive sram_rd = req_mem_ld & ~req_mem_stall and sram_addr = req_mem_addr[SRAM_AWIDTH+2:3] combinationally.
REQ-022 SHALL hold an accepted tag in one in-flight stage and write {tag, data} into the FIFO at the next edge; data is sram_q, or 0 for an errored address.
REQ-023 An errored address SHALL be addr[2:0]!=0 or any addr bit at or above SRAM_AWIDTH+3 set; it SHALL be answered normally, with data 0, and SHALL set err.
REQ-024 SHALL assert req_mem_stall combinationally when fifo_count + inflight >= FIFO_DEPTH, so the FIFO never overflows.
REQ-025 SHALL pop the FIFO head at an edge where the FIFO is non-empty and rsp_mem_stall=0, loading rsp_mem_tag and rsp_mem_q and setting rsp_mem_push=1 for one cycle.
REQ-026 Otherwise SHALL set rsp_mem_push=0 at that edge; rsp_mem_tag and rsp_mem_q SHALL hold their last values.
REQ-027 Latency: request accepted at edge E0 -> FIFO write at E1 -> rsp_mem_push high after E2, when unstalled; minimum 2 cycles.
REQ-028 Responses SHALL return in acceptance order with tags unmodified; back-to-back requests SHALL sustain one response per cycle.
REQ-029 On a simultaneous FIFO write and pop at the same edge, fifo_count SHALL stay unchanged; writing into an empty FIFO SHALL NOT bypass to the outputs in the same edge.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 rsp_count SHALL increment by 1 on every pop and wrap at 2^32.

Reset
REQ-032 While rst_n=0: rsp_mem_push=0, rsp_mem_tag=0, rsp_mem_q=0, err=0, rsp_count=0, fifo_count=0, pointers=0 and inflight=0.
REQ-033 While rst_n=0, req_mem_stall SHALL be 1, and sram_rd SHALL be 0.
REQ-034 Reset mid-operation SHALL discard all in-flight and queued responses, with no response after release.
REQ-035 The first request SHALL be accepted at the first edge after rst_n rises.

Verification
REQ-036 Single load: SRAM word 5 = 0xDEADBEEF00000001, request addr 0x28 tag 3 -> exactly 2 cycles later one push, tag 3, q 0xDEADBEEF00000001; rsp_count=1.
REQ-037 Streaming: 20 consecutive requests, addr 0,8,...,152, tags cycling 0..3, rsp_mem_stall=0 -> 20 in-order pushes on consecutive cycles; req_mem_stall never asserted.
REQ-038 Backpressure: hold rsp_mem_stall=1 while issuing 12 requests -> exactly FIFO_DEPTH=8 accepted, req_mem_stall=1 thereafter; release -> 8 in-order pushes, no loss or duplication.
REQ-039 Errors: addr 0x2C, then addr 1<<20, tags 1 and 2 -> both answered with q=0 and correct tags; err=1 from the first, and it stays 1.
REQ-040 Reset mid-stream: assert rst_n=0 with 5 queued responses -> push=0 immediately; after release, no stale pushes, rsp_count=0, and a new request responds in 2 cycles.
